// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared widths, FSM encoding and dump-length helper for reg_dump
package reg_dump_pkg;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } dump_state_t;

    // Inclusive word count from first to last, wrapping modulo 2**IDX_W (1..32).
    function automatic logic [IDX_W:0] dump_len(input logic [IDX_W-1:0] first,
                                                input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] span;
        span = last - first;
        return {1'b0, span} + {{IDX_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - streams a range of register-file entries through a 1-entry output register
module reg_dump
    import reg_dump_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [IDX_W-1:0]  dout_idx,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    dump_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   remaining;
    logic             slot_free;

    assign slot_free = !dout_valid || dout_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            remaining  <= '0;
            rd_addr    <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_idx   <= '0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // An accepted word empties the slot unless RUN refills it below.
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx       <= first_idx;
                        rd_addr   <= first_idx;
                        remaining <= dump_len(first_idx, last_idx);
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (slot_free) begin
                        dout_data  <= rd_data;
                        dout_idx   <= idx;
                        dout_valid <= 1'b1;
                        dout_last  <= (remaining == 1);
                        idx        <= idx + IDX_W'(1);
                        remaining  <= remaining - 1'b1;
                        // rd_addr tracks idx while words remain, then freezes on the last one.
                        if (remaining == 1) begin
                            state <= S_DRAIN;
                        end else begin
                            rd_addr <= idx + IDX_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (dout_valid && dout_ready && dout_last) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end

                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - randomized self-checking bench for reg_dump against a queue-based model
module tb_reg_dump;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [4:0]  dout_idx;
    logic        dout_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int          total;
    int          bad;
    int          exp_idx[$];
    logic [31:0] exp_data[$];
    int          last_acc_idx;

    assign rd_data = regs[rd_addr];

    reg_dump dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_idx   (dout_idx),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scores the handshake that the coming edge completes, then advances one cycle.
    task automatic step();
        logic        hold;
        logic [37:0] held;
        int          e_idx;
        logic [31:0] e_data;
        hold = dout_valid && !dout_ready;
        held = {dout_data, dout_idx, dout_last};
        if (dout_valid && dout_ready) begin
            if (exp_idx.size() == 0) begin
                check("extra_word", 64'(dout_idx), 64'hFFFF);
            end else begin
                e_idx  = exp_idx.pop_front();
                e_data = exp_data.pop_front();
                check("word_idx", 64'(dout_idx), 64'(e_idx));
                check("word_data", 64'(dout_data), 64'(e_data));
                check("word_last", 64'(dout_last), 64'(exp_idx.size() == 0));
            end
            last_acc_idx = int'(dout_idx);
        end
        tick();
        if (hold) check("hold_stable", 64'({dout_data, dout_idx, dout_last}), 64'(held));
    endtask

    task automatic load_model(input logic [4:0] f, input logic [4:0] l);
        int n;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        exp_idx.delete();
        exp_data.delete();
        for (int k = 0; k < n; k++) begin
            exp_idx.push_back((int'(f) + k) % 32);
            exp_data.push_back(regs[(int'(f) + k) % 32]);
        end
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int stall_idx,
                            input bit rnd_ready, input bit noise, input bit mutate,
                            input int exp_cycles);
        int cyc;
        int stall;
        bit seen_done;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        load_model(f, l);
        first_idx  = f;
        last_idx   = l;
        start      = 1'b1;
        dout_ready = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        cyc       = 0;
        stall     = 0;
        seen_done = 0;
        while (!seen_done && cyc < 400) begin
            if (stall_idx >= 0 && dout_valid && int'(dout_idx) == stall_idx && stall < 3) begin
                dout_ready = 1'b0;
                stall++;
                if (mutate) regs[stall_idx] = ~regs[stall_idx];
            end else begin
                dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                first_idx = 5'($urandom);
                last_idx  = 5'($urandom);
            end
            step();
            cyc++;
            if (exp_cycles > 0 && cyc == 1) check("first_valid_latency", 64'(dout_valid), 64'd1);
            if (done) seen_done = 1;
        end
        check("done_seen", 64'(seen_done), 64'd1);
        check("all_words_out", 64'(exp_idx.size()), 64'd0);
        if (exp_cycles > 0) check("dump_cycles", 64'(cyc), 64'(exp_cycles));
        if (stall_idx >= 0) check("stall_cycles", 64'(stall), 64'd3);
        start     = 1'b1;
        first_idx = 5'd0;
        last_idx  = 5'd0;
        step();
        start = 1'b0;
        check("done_one_cycle", 64'(done), 64'd0);
        check("start_at_done_ignored", 64'(busy), 64'd0);
        check("idle_no_valid", 64'(dout_valid), 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_acc_idx = -1;
        rst_n      = 1'b0;
        start      = 1'b0;
        first_idx  = '0;
        last_idx   = '0;
        dout_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        repeat (3) tick();
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_dout_data", 64'(dout_data), 64'd0);
        check("rst_dout_idx", 64'(dout_idx), 64'd0);
        check("rst_dout_last", 64'(dout_last), 64'd0);
        rst_n = 1'b1;
        tick();

        run_dump(5'd0, 5'd31, -1, 0, 0, 0, 33);
        run_dump(5'd5, 5'd7, 6, 0, 0, 0, 0);
        run_dump(5'd30, 5'd1, -1, 0, 0, 0, 5);
        run_dump(5'd9, 5'd9, -1, 0, 1, 0, 0);
        run_dump(5'd2, 5'd6, 4, 0, 0, 1, 0);

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        load_model(5'd0, 5'd31);
        first_idx    = 5'd0;
        last_idx     = 5'd31;
        start        = 1'b1;
        dout_ready   = 1'b1;
        last_acc_idx = -1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && last_acc_idx != 3; c++) step();
        check("reached_idx3", 64'(last_acc_idx), 64'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_valid", 64'(dout_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        exp_idx.delete();
        exp_data.delete();
        for (int c = 0; c < 5; c++) begin
            step();
            check("abort_quiet", 64'({dout_valid, done, busy}), 64'd0);
        end
        run_dump(5'd0, 5'd31, -1, 0, 0, 0, 33);

        for (int t = 0; t < 8; t++) begin
            run_dump(5'($urandom), 5'($urandom), -1, 1, t[0], 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
